// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic group: default operand width and
// the sequencing states used by the bit-serial datapaths.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full-subtractor cell: diff = a - b - bin, with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock.
// The start/busy/done handshake frames each operation; diff and borrow
// hold the last committed result until the next commit or reset.
module serial_sub
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_work_next;

  full_sub u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bin),
    .diff (w_d),
    .bout (w_bout)
  );

  // Working result after this cycle's bit enters at the MSB; after WIDTH
  // shifts bit 0 of the result has reached position 0.
  assign w_work_next = {w_d, r_work[WIDTH-1:1]};

  // Sequencer, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_work  <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work <= w_work_next;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_bin  <= w_bout;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff   <= w_work_next;
            r_borrow <= w_bout;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub with a result scoreboard.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb);
    exp_t e;
    e.d  = W'(ta - tb);
    e.br = (ta < tb);
    q.push_back(e);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = 'x;
    chk({tag, "_diff"}, 32'(diff), 32'(e.d));
    chk({tag, "_borrow"}, 32'(borrow), 32'(e.br));
  endtask

  // Accept one operation and follow it to completion, checking the
  // busy/done framing cycle by cycle. With scramble set, a/b change every
  // RUN cycle to show only the accept-edge values are used.
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input bit scramble);
    int busy_ok = 1;
    a = ta;
    b = tb;
    start = 1'b1;
    push_exp(ta, tb);
    step();                         // accepting edge k
    start = 1'b0;
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
    end
    chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    step();                         // edge k+W: commit
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    compare_result(tag);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin : main
    int done_edges[$];
    int held_ok;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    step();

    // Basic operations and boundary operands
    run_op("op5A_3C", 8'h5A, 8'h3C, 1'b0);
    run_op("op00_01", 8'h00, 8'h01, 1'b0);
    run_op("opFF_FF", 8'hFF, 8'hFF, 1'b0);
    run_op("op80_7F", 8'h80, 8'h7F, 1'b0);

    // start held high: accepts spaced WIDTH+2 apart, start ignored otherwise
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    for (int n = 0; n < 3; n++) push_exp(8'h10, 8'h01);
    held_ok = 1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (busy === 1'b1 && done === 1'b1) held_ok = 0;
      if (done === 1'b1) begin
        done_edges.push_back(e);
        compare_result("held");
      end else if (e > 8 && (diff !== 8'h0F || borrow !== 1'b0)) begin
        held_ok = 0;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_edges.size()), 32'd3);
    if (done_edges.size() == 3) begin
      chk("held_first_done", 32'(done_edges[0]), 32'd8);
      chk("held_spacing1", 32'(done_edges[1] - done_edges[0]), 32'd10);
      chk("held_spacing2", 32'(done_edges[2] - done_edges[1]), 32'd10);
    end
    chk("held_stable", 32'(held_ok), 32'd1);
    step();
    chk("held_idle", 32'(busy), 32'd0);

    // Operands changing during RUN
    run_op("scramble33_11", 8'h33, 8'h11, 1'b1);

    // Reset during RUN on the third RUN edge
    run_op("pre_rst", 8'h5A, 8'h3C, 1'b0);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    step();                         // accept
    start = 1'b0;
    step();                         // RUN edge 1
    step();                         // RUN edge 2
    rst = 1'b1;
    step();                         // RUN edge 3 with reset
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    step();
    chk("midrst_stay_idle", 32'(busy), 32'd0);
    run_op("op05_07", 8'h05, 8'h07, 1'b0);

    // rst and start at the same edge: reset wins
    a = 8'h44;
    b = 8'h22;
    start = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    run_op("after_rst_start", 8'h44, 8'h22, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
